// File: rtl/trace_matcher_if.sv
// Register-block <-> trace matcher bus: byte stream, rule settings and match results.
interface trace_matcher_if #(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
);
  logic [7:0]                           I_data;
  logic                                 I_data_valid;
  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_patterns;
  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_masks;
  logic [pMATCH_RULES-1:0]              I_pattern_enable;
  logic [pMATCH_RULES-1:0]              I_pattern_trig_enable;
  logic                                 I_reset_sync;
  logic                                 I_clear_counts;
  logic                                 O_synchronized;
  logic [pMATCH_RULES-1:0]              O_match;
  logic                                 O_trigger;
  logic [pMATCH_RULES*8-1:0]            O_counts;
  logic [pBUFFER_SIZE-1:0]              O_matched_data;

  modport master (
    output I_data, I_data_valid, I_patterns, I_masks, I_pattern_enable,
           I_pattern_trig_enable, I_reset_sync, I_clear_counts,
    input  O_synchronized, O_match, O_trigger, O_counts, O_matched_data
  );

  modport slave (
    input  I_data, I_data_valid, I_patterns, I_masks, I_pattern_enable,
           I_pattern_trig_enable, I_reset_sync, I_clear_counts,
    output O_synchronized, O_match, O_trigger, O_counts, O_matched_data
  );
endinterface

// File: rtl/trace_matcher.sv
// TPIU frame-sync tracker plus sliding byte window compared against masked rules;
// per-rule saturating counters, last matched window and a trigger pulse.
module trace_matcher #(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
) (
  input  logic           trace_clk,
  input  logic           reset_n,
  trace_matcher_if.slave bus
);
  localparam int DEPTH = pBUFFER_SIZE / 8;
  localparam int FW    = $clog2(DEPTH + 1);

  typedef enum logic {UNSYNC, SYNCED} state_t;

  state_t                  state, state_nx;
  // only the three bytes preceding the current one matter for sync detection
  logic [23:0]             sync_hist;
  logic [pBUFFER_SIZE-1:0] window, win_nx, md_q;
  logic [FW-1:0]           fill;
  logic [pMATCH_RULES-1:0] hit, match_q;
  logic                    trig_q, is_sync, byte_ev, eval;

  assign is_sync = bus.I_data_valid && !bus.I_reset_sync &&
                   ({sync_hist, bus.I_data} == 32'hFFFF_FF7F);
  assign byte_ev = bus.I_data_valid && !bus.I_reset_sync && !is_sync && (state == SYNCED);
  assign win_nx  = {window[pBUFFER_SIZE-9:0], bus.I_data};
  // window is full once this byte lands, i.e. fill already holds DEPTH-1 or more
  assign eval    = byte_ev && (fill >= FW'(DEPTH - 1));

  always_comb begin
    state_nx = state;
    if (bus.I_reset_sync)
      state_nx = UNSYNC;
    else if (is_sync)
      state_nx = SYNCED;
  end

  always_ff @(posedge trace_clk) begin
    if (!reset_n) state <= UNSYNC;
    else          state <= state_nx;
  end

  always_ff @(posedge trace_clk) begin
    if (!reset_n) begin
      sync_hist <= '0;
      window    <= '0;
      fill      <= '0;
      match_q   <= '0;
      trig_q    <= 1'b0;
      md_q      <= '0;
    end else begin
      match_q <= hit;
      trig_q  <= |(hit & bus.I_pattern_trig_enable);
      if (|hit) md_q <= win_nx;
      if (bus.I_reset_sync) begin
        sync_hist <= '0;
        window    <= '0;
        fill      <= '0;
      end else if (bus.I_data_valid) begin
        sync_hist <= {sync_hist[15:0], bus.I_data};
        if (is_sync) begin
          window <= '0;
          fill   <= '0;
        end else if (state == SYNCED) begin
          window <= win_nx;
          if (fill != FW'(DEPTH)) fill <= fill + FW'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < pMATCH_RULES; r++) begin : g_rule
    logic [pBUFFER_SIZE-1:0] pat, msk;
    logic [7:0]              cnt_q;

    assign pat    = bus.I_patterns[r*pBUFFER_SIZE +: pBUFFER_SIZE];
    assign msk    = bus.I_masks[r*pBUFFER_SIZE +: pBUFFER_SIZE];
    assign hit[r] = eval && bus.I_pattern_enable[r] && (((win_nx ^ pat) & msk) == '0);

    // clear wins over a same-cycle increment
    always_ff @(posedge trace_clk) begin
      if (!reset_n)                       cnt_q <= '0;
      else if (bus.I_clear_counts)        cnt_q <= '0;
      else if (hit[r] && cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
    end

    assign bus.O_counts[r*8 +: 8] = cnt_q;
  end

  assign bus.O_synchronized = (state == SYNCED);
  assign bus.O_match        = match_q;
  assign bus.O_trigger      = trig_q;
  assign bus.O_matched_data = md_q;
endmodule

// File: tb/tb_trace_matcher.sv
// Scenario bench for trace_matcher: behavioural model feeds a scoreboard checked every cycle,
// and each scenario task adds its own targeted checks.
module tb_trace_matcher;
  localparam int BW = 64;
  localparam int NR = 8;

  logic trace_clk;
  logic reset_n;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  trace_matcher_if #(.pBUFFER_SIZE(BW), .pMATCH_RULES(NR)) bus();

  trace_matcher #(.pBUFFER_SIZE(BW), .pMATCH_RULES(NR)) dut (
    .trace_clk (trace_clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  initial trace_clk = 1'b0;
  always #5 trace_clk = ~trace_clk;
  always @(posedge trace_clk) cyc++;

  typedef struct {
    int          chk;
    logic        sync;
    logic [7:0]  match;
    logic        trig;
    logic [63:0] counts;
    logic [63:0] md;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // reference model state
  logic        m_sync;
  logic [31:0] m_hist;
  logic [63:0] m_win, m_md;
  int          m_fill;
  logic [7:0]  m_cnt [NR];

  task automatic model_step(input logic v, input logic [7:0] d, input logic rs,
                            input logic clr, input logic rstn, output exp_t e);
    logic [7:0] match;
    logic [63:0] pat, msk;
    match = '0;
    if (!rstn) begin
      m_sync = 0; m_hist = '0; m_win = '0; m_fill = 0; m_md = '0;
      for (int r = 0; r < NR; r++) m_cnt[r] = '0;
    end else begin
      if (rs) begin
        m_sync = 0; m_hist = '0; m_win = '0; m_fill = 0;
      end else if (v) begin
        if ({m_hist[23:0], d} == 32'hFFFFFF7F) begin
          m_hist = {m_hist[23:0], d};
          m_sync = 1; m_win = '0; m_fill = 0;
        end else begin
          m_hist = {m_hist[23:0], d};
          if (m_sync) begin
            m_win = {m_win[55:0], d};
            if (m_fill < 8) m_fill++;
            if (m_fill == 8)
              for (int r = 0; r < NR; r++) begin
                pat = bus.I_patterns[r*64 +: 64];
                msk = bus.I_masks[r*64 +: 64];
                if (bus.I_pattern_enable[r] && ((m_win ^ pat) & msk) == 64'd0) match[r] = 1'b1;
              end
          end
        end
      end
      for (int r = 0; r < NR; r++)
        if (clr) m_cnt[r] = '0;
        else if (match[r] && m_cnt[r] != 8'hFF) m_cnt[r]++;
      if (match != 0) m_md = m_win;
    end
    e.sync  = m_sync;
    e.match = match;
    e.trig  = rstn && ((match & bus.I_pattern_trig_enable) != 0);
    for (int r = 0; r < NR; r++) e.counts[r*8 +: 8] = m_cnt[r];
    e.md    = m_md;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rs = 0,
                       input logic clr = 0, input logic rstn = 1);
    exp_t e;
    @(negedge trace_clk);
    bus.I_data_valid   = v;
    bus.I_data         = d;
    bus.I_reset_sync   = rs;
    bus.I_clear_counts = clr;
    reset_n            = rstn;
    model_step(v, d, rs, clr, rstn, e);
    e.chk = cyc + 1;
    q.push_back(e);
  endtask

  // scoreboard: outputs after edge N are compared against what was pushed before edge N
  always @(negedge trace_clk) begin
    while (q.size() > 0 && q[0].chk <= cyc) begin
      mon_e = q.pop_front();
      checks++; if (bus.O_synchronized !== mon_e.sync) begin errors++; $display("FAIL sb_sync cyc=%0d act=%b exp=%b", cyc, bus.O_synchronized, mon_e.sync); end
      checks++; if (bus.O_match !== mon_e.match) begin errors++; $display("FAIL sb_match cyc=%0d act=%h exp=%h", cyc, bus.O_match, mon_e.match); end
      checks++; if (bus.O_trigger !== mon_e.trig) begin errors++; $display("FAIL sb_trig cyc=%0d act=%b exp=%b", cyc, bus.O_trigger, mon_e.trig); end
      checks++; if (bus.O_counts !== mon_e.counts) begin errors++; $display("FAIL sb_counts cyc=%0d act=%h exp=%h", cyc, bus.O_counts, mon_e.counts); end
      checks++; if (bus.O_matched_data !== mon_e.md) begin errors++; $display("FAIL sb_md cyc=%0d act=%h exp=%h", cyc, bus.O_matched_data, mon_e.md); end
    end
  end

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_synchronized !== 1'b0) begin errors++; $display("FAIL rst_sync act=%b exp=0", bus.O_synchronized); end
    checks++; if (bus.O_match !== 8'h00) begin errors++; $display("FAIL rst_match act=%h exp=00", bus.O_match); end
    checks++; if (bus.O_trigger !== 1'b0) begin errors++; $display("FAIL rst_trig act=%b exp=0", bus.O_trigger); end
    checks++; if (bus.O_counts !== 64'd0) begin errors++; $display("FAIL rst_counts act=%h exp=0", bus.O_counts); end
    checks++; if (bus.O_matched_data !== 64'd0) begin errors++; $display("FAIL rst_md act=%h exp=0", bus.O_matched_data); end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_sync_fill();
    bus.I_patterns[63:0]     = 64'h0102030405060708;
    bus.I_masks[63:0]        = '1;
    bus.I_pattern_enable     = 8'h01;
    bus.I_pattern_trig_enable = 8'h01;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_synchronized !== 1'b0) begin errors++; $display("FAIL sf_presync act=%b exp=0", bus.O_synchronized); end
    drive(1'b1, 8'h7F);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_synchronized !== 1'b1) begin errors++; $display("FAIL sf_sync act=%b exp=1", bus.O_synchronized); end
    for (int b = 1; b <= 7; b++) begin
      drive(1'b1, 8'(b));
      @(posedge trace_clk); #1;
      checks++; if (bus.O_match !== 8'h00) begin errors++; $display("FAIL sf_nomatch byte=%0d act=%h exp=00", b, bus.O_match); end
    end
    drive(1'b1, 8'h08);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_match !== 8'h01) begin errors++; $display("FAIL sf_match act=%h exp=01", bus.O_match); end
    checks++; if (bus.O_trigger !== 1'b1) begin errors++; $display("FAIL sf_trig act=%b exp=1", bus.O_trigger); end
    checks++; if (bus.O_counts[7:0] !== 8'd1) begin errors++; $display("FAIL sf_cnt0 act=%0d exp=1", bus.O_counts[7:0]); end
    checks++; if (bus.O_matched_data !== 64'h0102030405060708) begin errors++; $display("FAIL sf_md act=%h exp=0102030405060708", bus.O_matched_data); end
    drive(1'b0, 8'h08);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_match !== 8'h00 || bus.O_trigger !== 1'b0) begin errors++; $display("FAIL sf_pulse match=%h trig=%b exp=00/0", bus.O_match, bus.O_trigger); end
  endtask

  task automatic test_mask_multi();
    bus.I_patterns[127:64]  = 64'h08;
    bus.I_masks[127:64]     = 64'hFF;
    bus.I_patterns[191:128] = 64'h08;
    bus.I_masks[191:128]    = 64'hFF;
    bus.I_pattern_enable      = 8'h07;
    bus.I_pattern_trig_enable = 8'h03;
    drive(1'b1, 8'h08);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_match !== 8'h06) begin errors++; $display("FAIL mm_match act=%h exp=06", bus.O_match); end
    checks++; if (bus.O_trigger !== 1'b1) begin errors++; $display("FAIL mm_trig act=%b exp=1", bus.O_trigger); end
    checks++; if (bus.O_counts[23:0] !== 24'h010101) begin errors++; $display("FAIL mm_cnts act=%h exp=010101", bus.O_counts[23:0]); end
    drive(1'b1, 8'h09);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_match !== 8'h00 || bus.O_trigger !== 1'b0) begin errors++; $display("FAIL mm_09 match=%h trig=%b exp=00/0", bus.O_match, bus.O_trigger); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) drive(1'b1, 8'h08);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_counts[15:8] !== 8'd255) begin errors++; $display("FAIL sat_cnt1 act=%0d exp=255", bus.O_counts[15:8]); end
    checks++; if (bus.O_match !== 8'h06) begin errors++; $display("FAIL sat_b2b act=%h exp=06", bus.O_match); end
    drive(1'b1, 8'h08, 1'b0, 1'b1);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_counts[15:8] !== 8'd0) begin errors++; $display("FAIL clr_cnt1 act=%0d exp=0", bus.O_counts[15:8]); end
    checks++; if (bus.O_match[1] !== 1'b1) begin errors++; $display("FAIL clr_match act=%b exp=1", bus.O_match[1]); end
    drive(1'b1, 8'h08);
    drive(1'b1, 8'h08);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_counts[15:8] !== 8'd2) begin errors++; $display("FAIL clr_recount act=%0d exp=2", bus.O_counts[15:8]); end
  endtask

  task automatic test_lost_sync();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h08, 1'b1);
      @(posedge trace_clk); #1;
      checks++; if (bus.O_synchronized !== 1'b0 || bus.O_match !== 8'h00) begin errors++; $display("FAIL ls_hold sync=%b match=%h exp=0/00", bus.O_synchronized, bus.O_match); end
    end
    checks++; if (bus.O_counts[15:8] !== 8'd2) begin errors++; $display("FAIL ls_kept act=%0d exp=2", bus.O_counts[15:8]); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h08);
      @(posedge trace_clk); #1;
      checks++; if (bus.O_match !== 8'h00) begin errors++; $display("FAIL ls_nosync act=%h exp=00", bus.O_match); end
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF);
    drive(1'b1, 8'h7F);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_synchronized !== 1'b1) begin errors++; $display("FAIL ls_resync act=%b exp=1", bus.O_synchronized); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'h08);
      @(posedge trace_clk); #1;
      checks++; if (bus.O_match !== 8'h00) begin errors++; $display("FAIL ls_fill act=%h exp=00", bus.O_match); end
    end
    drive(1'b1, 8'h08);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_match !== 8'h06) begin errors++; $display("FAIL ls_match act=%h exp=06", bus.O_match); end
  endtask

  task automatic test_resync_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF);
    drive(1'b1, 8'h7F);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_synchronized !== 1'b1 || bus.O_match !== 8'h00) begin errors++; $display("FAIL rs_sync sync=%b match=%h exp=1/00", bus.O_synchronized, bus.O_match); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'h08);
      @(posedge trace_clk); #1;
      checks++; if (bus.O_match !== 8'h00) begin errors++; $display("FAIL rs_fill act=%h exp=00", bus.O_match); end
    end
    drive(1'b1, 8'h08);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_match !== 8'h06) begin errors++; $display("FAIL rs_match act=%h exp=06", bus.O_match); end
    checks++; if (bus.O_counts[15:8] !== 8'd4) begin errors++; $display("FAIL rs_cnt1 act=%0d exp=4", bus.O_counts[15:8]); end
    drive(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    @(posedge trace_clk); #1;
    checks++; if (bus.O_synchronized !== 1'b0 || bus.O_match !== 8'h00 || bus.O_trigger !== 1'b0) begin errors++; $display("FAIL mr_ctl sync=%b match=%h trig=%b exp=0/00/0", bus.O_synchronized, bus.O_match, bus.O_trigger); end
    checks++; if (bus.O_counts !== 64'd0 || bus.O_matched_data !== 64'd0) begin errors++; $display("FAIL mr_data counts=%h md=%h exp=0/0", bus.O_counts, bus.O_matched_data); end
  endtask

  task automatic test_valid_gaps();
    logic [7:0] stream [12];
    int npulse, ntrig;
    stream[0] = 8'hFF; stream[1] = 8'hFF; stream[2] = 8'hFF; stream[3] = 8'h7F;
    for (int i = 0; i < 8; i++) stream[4+i] = 8'(i + 1);
    bus.I_pattern_enable      = 8'h01;
    bus.I_pattern_trig_enable = 8'h01;
    npulse = 0; ntrig = 0;
    for (int i = 0; i < 12; i++) begin
      for (int g = $urandom_range(3, 0); g > 0; g--) begin
        drive(1'b0, 8'($urandom));
        @(posedge trace_clk); #1;
        npulse += int'(bus.O_match[0]); ntrig += int'(bus.O_trigger);
      end
      drive(1'b1, stream[i]);
      @(posedge trace_clk); #1;
      npulse += int'(bus.O_match[0]); ntrig += int'(bus.O_trigger);
    end
    drive(1'b0, 8'h00);
    @(posedge trace_clk); #1;
    npulse += int'(bus.O_match[0]); ntrig += int'(bus.O_trigger);
    checks++; if (npulse != 1 || ntrig != 1) begin errors++; $display("FAIL vg_pulses match=%0d trig=%0d exp=1/1", npulse, ntrig); end
    checks++; if (bus.O_counts[7:0] !== 8'd1) begin errors++; $display("FAIL vg_cnt0 act=%0d exp=1", bus.O_counts[7:0]); end
    checks++; if (bus.O_matched_data !== 64'h0102030405060708) begin errors++; $display("FAIL vg_md act=%h exp=0102030405060708", bus.O_matched_data); end
  endtask

  initial begin
    reset_n                   = 1'b0;
    bus.I_data                = '0;
    bus.I_data_valid          = 1'b0;
    bus.I_patterns            = '0;
    bus.I_masks               = '0;
    bus.I_pattern_enable      = '0;
    bus.I_pattern_trig_enable = '0;
    bus.I_reset_sync          = 1'b0;
    bus.I_clear_counts        = 1'b0;
    test_reset();
    test_sync_fill();
    test_mask_multi();
    test_saturation();
    test_lost_sync();
    test_resync_reset();
    test_valid_gaps();
    drive(1'b0, 8'h00);
    repeat (3) @(negedge trace_clk);
    #1;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL sb_drain left=%0d exp=0", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_matcher.md
# trace_matcher

Per-byte ARM trace stream matcher sitting directly downstream of the trace register block in the trace clock domain. Consumes the deserialized trace byte stream plus the pattern, mask and enable settings produced by the register block. Detects TPIU frame synchronization, keeps a sliding window of recent bytes, and compares it against up to pMATCH_RULES masked patterns. Returns to the register block the synchronized flag, per-rule saturating match counts and the last matched window, and drives a trigger pulse.

## Interface
- pBUFFER_SIZE, 64: match window width in bits; multiple of 8, 32..64.
- pMATCH_RULES, 8: number of pattern/mask rules.
- trace_clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- I_data  in  8  trace byte.
- I_data_valid  in  1  I_data valid this cycle.
- I_patterns  in  pMATCH_RULES*pBUFFER_SIZE  rule r pattern at [r*pBUFFER_SIZE +: pBUFFER_SIZE].
- I_masks  in  pMATCH_RULES*pBUFFER_SIZE  rule r mask; bit 1 = compare, 0 = don't care.
- I_pattern_enable  in  pMATCH_RULES  rule enables.
- I_pattern_trig_enable  in  pMATCH_RULES  rule may fire O_trigger.
- I_reset_sync  in  1  level; forces loss of sync.
- I_clear_counts  in  1  one-cycle pulse; zeroes all counts.
- O_synchronized  out  1  high in SYNCED state.
- O_match  out  pMATCH_RULES  per-rule one-cycle match pulse.
- O_trigger  out  1  one-cycle trigger pulse.
- O_counts  out  pMATCH_RULES*8  rule r count at [r*8 +: 8].
- O_matched_data  out  pBUFFER_SIZE  window at the most recent match.

## Operation
- States: UNSYNC, SYNCED. Reset state: UNSYNC.
- Sync detector:
  - A 32-bit history of valid bytes is always maintained.
  - A sync is a valid byte 0x7F that completes the sequence 0xFF, 0xFF, 0xFF, 0x7F.
  - On sync: UNSYNC goes to SYNCED. Window and fill counter clear. The 0x7F is not shifted into the window.
  - In SYNCED, a repeated sync clears window and fill again and stays SYNCED.
- I_reset_sync high: go to UNSYNC and clear window, fill counter and sync history. Bytes are ignored while it is high. Counts and O_matched_data are kept.
- Window:
  - In SYNCED, each valid non-sync byte updates window <= {window[pBUFFER_SIZE-9:0], I_data}, so the newest byte sits in [7:0].
  - The fill counter increments up to pBUFFER_SIZE/8 and saturates there.
- Match evaluation:
  - Evaluated only on a valid non-sync byte in SYNCED, against the post-shift window w.
  - Evaluated only when the fill counter, including the current byte, is at least pBUFFER_SIZE/8.
  - Rule r matches when I_pattern_enable[r] = 1 and ((w ^ pattern_r) & mask_r) == 0.
- On any match:
  - O_match bits set for every matching rule.
  - Each matching rule's count increments and saturates at 255.
  - O_matched_data <= w.
  - O_trigger = 1 if any matching rule has I_pattern_trig_enable set; one pulse even when several rules match.
- Priority: reset_n > I_reset_sync > I_clear_counts (counts only) > sync detect > byte processing.
- I_clear_counts in the same cycle as a match: counts become 0, not 1. O_match, O_trigger and O_matched_data still update.
- Reset values: O_synchronized 0, O_match 0, O_trigger 0, O_counts 0, O_matched_data 0, window 0, fill 0, sync history 0.

## Timing
- All outputs are registered.
- Byte sampled at edge E: O_match, O_trigger, O_matched_data and the count update are visible after E, i.e. 1-cycle latency.
- O_synchronized rises at the edge that samples the 0x7F.
- Matching can start on the pBUFFER_SIZE/8-th valid byte after the sync.
- O_match and O_trigger are high for exactly one cycle per matching byte. Back-to-back matching bytes give back-to-back pulses.
- Invalid cycles change nothing. Gaps in I_data_valid do not break the byte sequence.
- I_patterns, I_masks and the enables are quasi-static; a change applies from the next evaluated byte.
- reset_n low for one edge sets every reset value at that edge, including mid-stream.

## Test plan
- Sync then fill:
  - Stimulus: feed FF FF FF 7F, then bytes 01..08 with pBUFFER_SIZE=64. Rule 0: pattern 0x0102030405060708, mask all-ones, enabled, trig enabled.
  - Response: O_synchronized rises with the 7F. O_match[0] and O_trigger pulse once, one cycle after byte 08. Count0 = 1. O_matched_data = 0x0102030405060708. No match on bytes 01..07.
- Mask and multi-rule:
  - Stimulus: rule 1 has mask 0x00000000000000FF, pattern 0x08. Rule 2 uses the same pattern and mask but trig disabled. Send byte 08 in a full window.
  - Response: O_match = 0x06, a single O_trigger pulse, count1 and count2 each +1.
  - Stimulus: then send byte 09.
  - Response: no match.
- Saturation and clear:
  - Stimulus: 300 matching bytes for rule 1.
  - Response: count1 holds at 255.
  - Stimulus: I_clear_counts pulsed in the same cycle as a matching byte.
  - Response: count1 = 0, O_match[1] still pulses.
- Lost sync:
  - Stimulus: I_reset_sync high for 3 cycles with matching bytes presented.
  - Response: O_synchronized = 0, no O_match, counts kept.
  - Stimulus: after release, 8 bytes without a sync.
  - Response: no match until FF FF FF 7F is seen plus 8 more bytes.
- Resync and reset mid-stream:
  - Stimulus: a sync sequence inside the data stream.
  - Response: window and fill clear; the next match requires 8 new bytes.
  - Stimulus: reset_n low for one cycle while SYNCED.
  - Response: all outputs at reset values on the next cycle.
- Valid gaps:
  - Stimulus: the Sync then fill stream with random idle cycles inserted.
  - Response: identical matches, counts and O_matched_data.
